// File: rtl/alu_4bit_pkg.sv
// Shared constants and opcode encoding for the 4-bit ALU.
// Flag outputs (zero, ovf) are built only when ALU_4BIT_FLAGS_EN is defined.
package alu_4bit_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_AND = OP_AND,
    ALU_OR  = OP_OR,
    ALU_XOR = OP_XOR,
    ALU_NOT = OP_NOT,
    ALU_SHL = OP_SHL,
    ALU_SHR = OP_SHR
  } opcode_e;

endpackage

// File: rtl/alu_4bit_adder.sv
// Ripple-carry adder shared by ADD and SUB (SUB feeds ~b).
// Signed overflow is the carry into the MSB differing from the carry out.
module alu_4bit_adder
  import alu_4bit_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o
);

  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[W];
  assign ovf_o  = c[W] ^ c[W-1];

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: opcode mux feeding output registers, one-cycle latency.
// Define ALU_4BIT_FLAGS_EN to add the registered zero and ovf outputs.
module alu_4bit
  import alu_4bit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] finalout,
  input  logic         cin,
  output logic         cout,
  input  logic [2:0]   ctrl
`ifdef ALU_4BIT_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  opcode_e      op;
  logic [W-1:0] add_b, add_sum;
  logic         add_cout, add_ovf;
  logic [W-1:0] finalout_d, finalout_q;
  logic         cout_d, cout_q;

  assign op    = opcode_e'(ctrl);
  assign add_b = (op == ALU_SUB) ? ~b : b;

  alu_4bit_adder u_adder (
    .a_i    (a),
    .b_i    (add_b),
    .cin_i  (cin),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    finalout_d = '0;
    cout_d     = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        finalout_d = add_sum;
        cout_d     = add_cout;
      end
      ALU_AND: finalout_d = a & b;
      ALU_OR:  finalout_d = a | b;
      ALU_XOR: finalout_d = a ^ b;
      ALU_NOT: finalout_d = ~a;
      ALU_SHL: begin
        finalout_d = {a[W-2:0], 1'b0};
        cout_d     = a[W-1];
      end
      ALU_SHR: begin
        finalout_d = {1'b0, a[W-1:1]};
        cout_d     = a[0];
      end
      default: begin
        finalout_d = '0;
        cout_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finalout_q <= '0;
      cout_q     <= 1'b0;
    end else begin
      finalout_q <= finalout_d;
      cout_q     <= cout_d;
    end
  end

  assign finalout = finalout_q;
  assign cout     = cout_q;

`ifdef ALU_4BIT_FLAGS_EN
  logic zero_d, zero_q, ovf_d, ovf_q;

  assign zero_d = (finalout_d == '0);
  // Overflow only has meaning for the adder paths.
  assign ovf_d  = (op == ALU_ADD || op == ALU_SUB) ? add_ovf : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = add_ovf;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed cases, random ops, back-to-back and mid-stream reset.
// Flag checks are compiled in only when ALU_4BIT_FLAGS_EN is defined.
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [3:0] finalout;
  logic       cin;
  logic       cout;
  logic [2:0] ctrl;
`ifdef ALU_4BIT_FLAGS_EN
  logic       zero, ovf;
`endif

  int checks = 0;
  int failures = 0;

  alu_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .finalout (finalout),
    .cin      (cin),
    .cout     (cout),
    .ctrl     (ctrl)
`ifdef ALU_4BIT_FLAGS_EN
    ,
    .zero     (zero),
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: returns {ovf, zero, c, r[3:0]} using integer arithmetic.
  function automatic logic [6:0] model(input int op, input int av, input int bv, input int ci);
    int s, r, c, ov, bo, sa, sb, ss;
    r = 0; c = 0; ov = 0;
    case (op)
      0, 1: begin
        bo = (op == 1) ? (15 - bv) : bv;
        s  = av + bo + ci;
        r  = s % 16;
        c  = (s >= 16) ? 1 : 0;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bo >= 8) ? bo - 16 : bo;
        ss = sa + sb + ci;
        ov = (ss > 7 || ss < -8) ? 1 : 0;
      end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = 15 - av;
      6: begin r = (av * 2) % 16; c = av / 8; end
      default: begin r = av / 2; c = av % 2; end
    endcase
    return {ov[0], (r == 0), c[0], r[3:0]};
  endfunction

  task automatic drive(input int op, input int av, input int bv, input int ci);
    @(negedge clk);
    ctrl = op[2:0]; a = av[3:0]; b = bv[3:0]; cin = ci[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    ctrl = 3'b000; a = 4'hF; b = 4'h1; cin = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (finalout !== 4'h0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: finalout=%b cout=%b want 0000/0", finalout, cout);
    end
`ifdef ALU_4BIT_FLAGS_EN
    checks++;
    if (zero !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: zero=%b ovf=%b want 0/0", zero, ovf);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (finalout !== 4'h0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: finalout=%b cout=%b want 0000/0", finalout, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 3, 4, 1);
    e = model(0, 3, 4, 1);
    checks++;
    if (finalout !== e[3:0] || cout !== e[4]) begin
      failures++;
      $display("FAIL reset_release: finalout=%b cout=%b want %b/%b", finalout, cout, e[3:0], e[4]);
    end
  endtask

  task automatic test_add();
    drive(0, 4'b1000, 4'b0001, 0);
    checks++;
    if (finalout !== 4'b1001 || cout !== 1'b0) begin
      failures++;
      $display("FAIL add_basic: finalout=%b cout=%b want 1001/0", finalout, cout);
    end
`ifdef ALU_4BIT_FLAGS_EN
    checks++;
    if (ovf !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL add_basic_flags: ovf=%b zero=%b want 0/0", ovf, zero);
    end
`endif
    drive(0, 4'b1111, 4'b0001, 0);
    checks++;
    if (finalout !== 4'b0000 || cout !== 1'b1) begin
      failures++;
      $display("FAIL add_wrap: finalout=%b cout=%b want 0000/1", finalout, cout);
    end
`ifdef ALU_4BIT_FLAGS_EN
    checks++;
    if (zero !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL add_wrap_flags: zero=%b ovf=%b want 1/0", zero, ovf);
    end
`endif
  endtask

  task automatic test_sub();
    drive(1, 4'b1000, 4'b0001, 1);
    checks++;
    if (finalout !== 4'b0111 || cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_basic: finalout=%b cout=%b want 0111/1", finalout, cout);
    end
`ifdef ALU_4BIT_FLAGS_EN
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL sub_ovf: ovf=%b want 1", ovf);
    end
`endif
    drive(1, 4'b0001, 4'b0010, 1);
    checks++;
    if (finalout !== 4'b1111 || cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow: finalout=%b cout=%b want 1111/0", finalout, cout);
    end
  endtask

  task automatic test_logic();
    logic [3:0] want [4] = '{4'b0000, 4'b1001, 4'b1001, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      drive(2 + i, 4'b1000, 4'b0001, 1);
      checks++;
      if (finalout !== want[i] || cout !== 1'b0) begin
        failures++;
        $display("FAIL logic_op%0d: finalout=%b cout=%b want %b/0", 2 + i, finalout, cout, want[i]);
      end
`ifdef ALU_4BIT_FLAGS_EN
      checks++;
      if (zero !== (want[i] == 4'b0000) || ovf !== 1'b0) begin
        failures++;
        $display("FAIL logic_flags_op%0d: zero=%b ovf=%b", 2 + i, zero, ovf);
      end
`endif
    end
  endtask

  task automatic test_shift();
    drive(6, 4'b1000, 4'b1111, 1);
    checks++;
    if (finalout !== 4'b0000 || cout !== 1'b1) begin
      failures++;
      $display("FAIL shl: finalout=%b cout=%b want 0000/1", finalout, cout);
    end
    drive(7, 4'b1000, 4'b1111, 1);
    checks++;
    if (finalout !== 4'b0100 || cout !== 1'b0) begin
      failures++;
      $display("FAIL shr: finalout=%b cout=%b want 0100/0", finalout, cout);
    end
    drive(7, 4'b0011, 4'b0000, 0);
    checks++;
    if (finalout !== 4'b0001 || cout !== 1'b1) begin
      failures++;
      $display("FAIL shr_lsb: finalout=%b cout=%b want 0001/1", finalout, cout);
    end
  endtask

  task automatic test_random();
    int op, av, bv, ci;
    logic [6:0] e;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7); av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15); ci = $urandom_range(0, 1);
      drive(op, av, bv, ci);
      e = model(op, av, bv, ci);
      checks++;
      if (finalout !== e[3:0] || cout !== e[4]) begin
        failures++;
        $display("FAIL random op=%0d a=%0d b=%0d cin=%0d: finalout=%b cout=%b want %b/%b",
                 op, av, bv, ci, finalout, cout, e[3:0], e[4]);
      end
`ifdef ALU_4BIT_FLAGS_EN
      checks++;
      if (zero !== e[5] || ovf !== e[6]) begin
        failures++;
        $display("FAIL random_flags op=%0d a=%0d b=%0d cin=%0d: zero=%b ovf=%b want %b/%b",
                 op, av, bv, ci, zero, ovf, e[5], e[6]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e, prev;
    int av, bv, ci;
    prev = {3'b000, cout, finalout};
    for (int op = 0; op < 8; op++) begin
      av = $urandom_range(0, 15); bv = $urandom_range(0, 15); ci = $urandom_range(0, 1);
      @(negedge clk);
      ctrl = op[2:0]; a = av[3:0]; b = bv[3:0]; cin = ci[0];
      #1;
      checks++;
      if (finalout !== prev[3:0] || cout !== prev[4]) begin
        failures++;
        $display("FAIL b2b_hold op=%0d: finalout=%b cout=%b want %b/%b", op, finalout, cout, prev[3:0], prev[4]);
      end
      @(posedge clk); #1;
      e = model(op, av, bv, ci);
      checks++;
      if (finalout !== e[3:0] || cout !== e[4]) begin
        failures++;
        $display("FAIL b2b_result op=%0d: finalout=%b cout=%b want %b/%b", op, finalout, cout, e[3:0], e[4]);
      end
      prev = e;
    end
    // Inputs that yield a non-zero result so the async clear is observable.
    @(negedge clk);
    ctrl = 3'b101; a = 4'b0000; b = 4'b0000; cin = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (finalout !== 4'h0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: finalout=%b cout=%b want 0000/0", finalout, cout);
    end
    @(posedge clk); #1;
    checks++;
    if (finalout !== 4'h0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_hold: finalout=%b cout=%b want 0000/0", finalout, cout);
    end
`ifdef ALU_4BIT_FLAGS_EN
    checks++;
    if (zero !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags: zero=%b ovf=%b want 0/0", zero, ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(6, 4'b1001, 4'b0000, 0);
    checks++;
    if (finalout !== 4'b0010 || cout !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release: finalout=%b cout=%b want 0010/1", finalout, cout);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
